// File: rtl/c3a_pkg.sv
// ============================================================================
//  Module   : c3a_pkg
//  Purpose  : Shared constants and types for the c3a down counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package c3a_pkg;

  // Default number of counter bits.
  localparam int C3A_WIDTH_DEFAULT = 3;

  // Count value at the default width.
  typedef logic [C3A_WIDTH_DEFAULT-1:0] c3a_count_t;

endpackage : c3a_pkg

`default_nettype wire

// File: rtl/c3a_tstage.sv
// ============================================================================
//  Module   : c3a_tstage
//  Purpose  : One toggle stage: an XOR feeding an async-reset D flop, with a
//             complemented output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c3a_tstage
  import c3a_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic tog,
  output logic q,
  output logic qn
);

  logic state_q;
  logic state_d;

  // Toggle when requested, otherwise hold.
  always_comb begin
    state_d = state_q ^ tog;
  end

  // State flop; reset clears the stage immediately, independent of clk.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q  = state_q;
  assign qn = ~state_q;

endmodule : c3a_tstage

`default_nettype wire

// File: rtl/c3a_counter.sv
// ============================================================================
//  Module   : c3a_counter
//  Purpose  : Modulo-2^WIDTH synchronous down counter built from toggle
//             stages; out_n is the bitwise complement and counts up.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c3a_counter
  import c3a_pkg::*;
#(
  parameter int WIDTH = C3A_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             res,
  input  logic             t,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_n
);

  // Per-stage toggle requests.
  logic [WIDTH-1:0] w_tog;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      // A stage toggles when every lower bit is zero, which is the
      // single-clock equivalent of a ripple stage clocked by the rising edge
      // of its predecessor's output. Each bit is formed directly from the
      // count rather than from the previous request to keep the logic flat.
      if (i == 0) begin : g_lsb
        assign w_tog[i] = t;
      end else begin : g_upper
        assign w_tog[i] = t & ~(|out[i-1:0]);
      end

      c3a_tstage u_stage (
        .clk (clk),
        .res (res),
        .tog (w_tog[i]),
        .q   (out[i]),
        .qn  (out_n[i])
      );
    end
  endgenerate

endmodule : c3a_counter

`default_nettype wire

// File: tb/tb_c3a_counter.sv
// ============================================================================
//  Module   : tb_c3a_counter
//  Purpose  : Scoreboard testbench for c3a_counter at WIDTH=3 and WIDTH=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c3a_counter;

  logic       clk;
  logic       res;
  logic       t;
  logic       res4;
  logic       t4;
  logic [2:0] out3;
  logic [2:0] out3_n;
  logic [3:0] out4;
  logic [3:0] out4_n;

  int checks;
  int errors;

  // Scoreboard: parallel queues of DUT select, expected count and label.
  int         sb_sel[$];
  logic [3:0] sb_exp[$];
  string      sb_name[$];
  event       chk_ev;

  c3a_counter #(.WIDTH(3)) u_dut3 (
    .clk   (clk),
    .res   (res),
    .t     (t),
    .out   (out3),
    .out_n (out3_n)
  );

  c3a_counter #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .res   (res4),
    .t     (t4),
    .out   (out4),
    .out_n (out4_n)
  );

  // Rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push one expectation and request a sample.
  task automatic expect_cnt(input int sel, input logic [3:0] exp, input string name);
    sb_sel.push_back(sel);
    sb_exp.push_back(exp);
    sb_name.push_back(name);
    -> chk_ev;
  endtask

  // Monitor: 1 time unit after a request, drain and compare all entries.
  initial begin
    int         sel;
    logic [3:0] exp;
    logic [3:0] exp_n;
    logic [3:0] act;
    logic [3:0] act_n;
    string      name;
    forever begin
      @(chk_ev);
      #1;
      while (sb_exp.size() > 0) begin
        sel  = sb_sel.pop_front();
        exp  = sb_exp.pop_front();
        name = sb_name.pop_front();
        if (sel == 3) begin
          act   = {1'b0, out3};
          act_n = {1'b0, out3_n};
          exp_n = ~exp & 4'h7;
        end else begin
          act   = out4;
          act_n = out4_n;
          exp_n = ~exp & 4'hF;
        end
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL %s out (w%0d) t=%0t: got %0d expected %0d", name, sel, $time, act, exp);
        end
        checks++;
        if (act_n !== exp_n) begin
          errors++;
          $display("FAIL %s out_n (w%0d) t=%0t: got %0d expected %0d", name, sel, $time, act_n, exp_n);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    logic [3:0] seq3 [16];
    logic [3:0] seq4 [17];
    seq3 = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
             4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    seq4 = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
             4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1, 4'd0, 4'd15};
    checks = 0;
    errors = 0;
    res  = 1'b1;
    t    = 1'b1;
    res4 = 1'b1;
    t4   = 1'b1;

    // Reset held across edges 5 and 15 with t=1.
    #16;
    expect_cnt(3, 4'd0, "rst_hold");
    expect_cnt(4, 4'd0, "rst4_hold");

    // Release between edges at 22: still 0 until edge 25.
    #6;
    res = 1'b0;
    expect_cnt(3, 4'd0, "rel_pre_edge");

    // Two full wraps: edges 25..175.
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      expect_cnt(3, seq3[k], "wrap");
    end

    // Count down to 5: edges 185, 195, 205.
    @(posedge clk); expect_cnt(3, 4'd7, "to5");
    @(posedge clk); expect_cnt(3, 4'd6, "to5");
    @(posedge clk); expect_cnt(3, 4'd5, "to5");

    // Hold for 4 edges.
    @(negedge clk);
    t = 1'b0;
    repeat (4) begin
      @(posedge clk);
      expect_cnt(3, 4'd5, "hold");
    end

    // Re-enable: next edge gives 4.
    @(negedge clk);
    t = 1'b1;
    @(posedge clk);
    expect_cnt(3, 4'd4, "hold_exit");

    // Async reset mid-count at 262, checked before edge 265.
    #7;
    res = 1'b1;
    expect_cnt(3, 4'd0, "async_rst");

    // Reset wins over edges while t=1.
    repeat (3) begin
      @(posedge clk);
      expect_cnt(3, 4'd0, "rst_vs_edge");
    end

    // Release at 292; first enabled edge gives 7.
    #7;
    res = 1'b0;
    expect_cnt(3, 4'd0, "rel2_pre_edge");
    @(posedge clk); expect_cnt(3, 4'd7, "rel2_first");
    @(posedge clk); expect_cnt(3, 4'd6, "rel2_second");

    // WIDTH=4 instance: held in reset until 312, then 15..0,15.
    #7;
    expect_cnt(4, 4'd0, "w4_rst_hold");
    res4 = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
      expect_cnt(4, seq4[k], "w4_wrap");
    end

    // Let the monitor drain, then confirm nothing was left unchecked.
    #5;
    checks++;
    if (sb_exp.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries expected 0", sb_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_c3a_counter

`default_nettype wire
